lcd1602_textmod: RTL and testbench

//  Upstream text source for the LCD1602 control/function chain. Holds a 32-char shadow screen (2 lines x 16),

---
 rtl/lcd1602_textmod_pkg.sv | 28 ++
 rtl/lcd1602_textmod_bin2bcd.sv | 55 +++++
 rtl/lcd1602_textmod.sv | 191 +++++++++++++++++++
 tb/tb_lcd1602_textmod.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd1602_textmod_pkg.sv
// Shared constants, state encodings and a digit helper for the LCD1602 text source
// and any other block that drives or models the controller's line images.
package lcd1602_textmod_pkg;

   localparam logic [7:0] CHAR_SPACE   = 8'h20;
   localparam logic [7:0] CHAR_ZERO    = 8'h30;
   localparam int         LINE_CHARS   = 16;
   localparam int         SCREEN_CHARS = 32;
   localparam int         ADDR_W       = 5;

   typedef enum logic [1:0] {
      F_IDLE,
      F_SHIFT,
      F_WRITE,
      F_DONE
   } fmt_state_t;

   typedef enum logic {
      R_IDLE,
      R_BUSY
   } ref_state_t;

   // ASCII code of one BCD digit
   function automatic logic [7:0] digit_char(input logic [3:0] nib);
      return CHAR_ZERO + {4'h0, nib};
   endfunction

endpackage

// File: rtl/lcd1602_textmod_bin2bcd.sv
// Sequential double-dabble converter: one binary bit per cycle, MSB first.
// done is high during the final shift cycle; bcd holds its result until the next start.
module lcd1602_textmod_bin2bcd #(
   parameter int NUM_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [NUM_W-1:0]    bin,
   output logic [4*DIGITS-1:0] bcd,
   output logic                done
);

   localparam int CNT_W = $clog2(NUM_W);

   logic [NUM_W-1:0]    bin_sh;
   logic [CNT_W-1:0]    bit_cnt;
   logic                run;
   logic [4*DIGITS-1:0] bcd_adj;
   logic                unused_msb;

   // add-3 correction on every nibble that is 5 or more before it is doubled
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // the top BCD bit is shifted out: values wider than DIGITS digits keep only the low digits
   assign unused_msb = bcd_adj[4*DIGITS-1];
   assign done       = run && (bit_cnt == CNT_W'(NUM_W - 1));

   // load on start, then shift one bit per cycle for NUM_W cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_sh  <= '0;
         bcd     <= '0;
         bit_cnt <= '0;
         run     <= 1'b0;
      end else if (start) begin
         bin_sh  <= bin;
         bcd     <= '0;
         bit_cnt <= '0;
         run     <= 1'b1;
      end else if (run) begin
         bcd     <= {bcd_adj[4*DIGITS-2:0], bin_sh[NUM_W-1]};
         bin_sh  <= {bin_sh[NUM_W-2:0], 1'b0};
         bit_cnt <= bit_cnt + 1'b1;
         if (done) run <= 1'b0;
      end
   end

endmodule

// File: rtl/lcd1602_textmod.sv
// 32-cell shadow screen feeding the LCD1602 controller. Accepts char writes and
// renders unsigned numbers as right-aligned decimal, then hands frozen line images
// to the controller through the oCall/iDone handshake.
// Build option: define LCD1602_ZERO_BLANK_EN to print leading zeros as spaces.
module lcd1602_textmod
   import lcd1602_textmod_pkg::*;
#(
   parameter int         NUM_W     = 16,
   parameter int         DIGITS    = 5,
   parameter logic [7:0] INIT_CHAR = CHAR_SPACE
) (
   input  logic              CLOCK,
   input  logic              RST_n,
   input  logic              iWrEn,
   input  logic [ADDR_W-1:0] iWrAddr,
   input  logic [7:0]        iWrChar,
   input  logic              iNumCall,
   input  logic [NUM_W-1:0]  iNum,
   input  logic [ADDR_W-1:0] iNumPos,
   output logic              oNumBusy,
   output logic              oNumDone,
   output logic [127:0]      line_rom1,
   output logic [127:0]      line_rom2,
   output logic              oCall,
   input  logic              iDone
);

   localparam int            K_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(DIGITS - 1);

   fmt_state_t          f_state, f_next;
   ref_state_t          r_state, r_next;
   logic [ADDR_W-1:0]   num_pos;
   logic [K_W-1:0]      dig_k;
   logic [4*DIGITS-1:0] bcd;
   logic                bcd_start, bcd_done;
   logic                fmt_wr;
   logic [3:0]          fmt_nib;
   logic [7:0]          fmt_char;
   logic                wr_any;
   logic [ADDR_W-1:0]   wr_addr;
   logic [7:0]          wr_data;
   logic [7:0]          shadow [SCREEN_CHARS];
   logic                dirty, snap;
   logic [127:0]        img1, img2;

   assign bcd_start = (f_state == F_IDLE) && iNumCall;

   lcd1602_textmod_bin2bcd #(
      .NUM_W (NUM_W),
      .DIGITS(DIGITS)
   ) u_bin2bcd (
      .clk  (CLOCK),
      .rst_n(RST_n),
      .start(bcd_start),
      .bin  (iNum),
      .bcd  (bcd),
      .done (bcd_done)
   );

   // formatter state register
   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) f_state <= F_IDLE;
      else        f_state <= f_next;
   end

   // formatter next state; a char write steals the shadow port and stalls the digit write
   // NOTE: defaults first, so no path through the block leaves a variable unassigned (no latch).
   always_comb begin
      f_next = f_state;
      fmt_wr = 1'b0;
      case (f_state)
         F_IDLE:  if (iNumCall) f_next = F_SHIFT;
         F_SHIFT: if (bcd_done) f_next = F_WRITE;
         F_WRITE: begin
            if (!iWrEn) begin
               fmt_wr = 1'b1;
               if (dig_k == K_LAST) f_next = F_DONE;
            end
         end
         F_DONE:  f_next = F_IDLE;
         default: f_next = F_IDLE;
      endcase
   end

   assign oNumBusy = (f_state != F_IDLE);
   assign oNumDone = (f_state == F_DONE);

   // position and digit index, captured on accept and advanced per written digit
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         num_pos <= '0;
         dig_k   <= '0;
      end else if (bcd_start) begin
         num_pos <= iNumPos;
         dig_k   <= '0;
      end else if (fmt_wr) begin
         dig_k   <= dig_k + 1'b1;
      end
   end

   // select the current digit, most significant first
   always_comb begin
      fmt_nib = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_k == K_W'(i)) fmt_nib = bcd[4*(DIGITS-1-i) +: 4];
      end
   end

`ifdef LCD1602_ZERO_BLANK_EN
   logic lead_zero;

   // stays set while every digit written so far was a zero
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n)                            lead_zero <= 1'b1;
      else if (bcd_start)                    lead_zero <= 1'b1;
      else if (fmt_wr && (fmt_nib != 4'h0))  lead_zero <= 1'b0;
   end

   // the units digit is always shown so that zero renders as "0"
   assign fmt_char = (lead_zero && (fmt_nib == 4'h0) && (dig_k != K_LAST)) ?
                     CHAR_SPACE : digit_char(fmt_nib);
`else
   assign fmt_char = digit_char(fmt_nib);
`endif

   // single write port: external char writes win, digit address wraps 31 -> 0
   assign wr_any  = iWrEn | fmt_wr;
   assign wr_addr = iWrEn ? iWrAddr : (num_pos + ADDR_W'(dig_k));
   assign wr_data = iWrEn ? iWrChar : fmt_char;

   // shadow screen
   // NOTE: this memory is reset because a blank screen must be visible right after reset.
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 0; i < SCREEN_CHARS; i++) shadow[i] <= INIT_CHAR;
      end else if (wr_any) begin
         shadow[wr_addr] <= wr_data;
      end
   end

   // pack shadow cells into line images, leftmost char in the top byte
   always_comb begin
      img1 = '0;
      img2 = '0;
      for (int i = 0; i < LINE_CHARS; i++) begin
         img1[127-8*i -: 8] = shadow[i];
         img2[127-8*i -: 8] = shadow[LINE_CHARS+i];
      end
   end

   assign snap = (r_state == R_IDLE) && dirty;

   // refresh state register
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   // refresh next state: snapshot when dirty, wait for the controller's iDone
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (dirty) r_next = R_BUSY;
         R_BUSY:  if (iDone) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   assign oCall = (r_state == R_BUSY);

   // dirty flag: a write in the snapshot cycle wins, forcing another refresh
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n)      dirty <= 1'b1;
      else if (wr_any) dirty <= 1'b1;
      else if (snap)   dirty <= 1'b0;
   end

   // line images change only on a snapshot, so they stay frozen while the controller works
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         line_rom1 <= {LINE_CHARS{INIT_CHAR}};
         line_rom2 <= {LINE_CHARS{INIT_CHAR}};
      end else if (snap) begin
         line_rom1 <= img1;
         line_rom2 <= img2;
      end
   end

endmodule

// File: tb/tb_lcd1602_textmod.sv
// Scoreboard bench for lcd1602_textmod: the stimulus pushes expected screens and
// oNumDone cycles; a monitor pops and compares on each oCall rise / oNumDone pulse.
module tb_lcd1602_textmod;

   localparam int LAT = 16 + 5 + 1;

   logic         CLOCK = 1'b0;
   logic         RST_n = 1'b0;
   logic         iWrEn = 1'b0;
   logic [4:0]   iWrAddr = '0;
   logic [7:0]   iWrChar = '0;
   logic         iNumCall = 1'b0;
   logic [15:0]  iNum = '0;
   logic [4:0]   iNumPos = '0;
   logic         iDone = 1'b0;
   logic         oNumBusy, oNumDone, oCall;
   logic [127:0] line_rom1, line_rom2;

   lcd1602_textmod dut (
      .CLOCK    (CLOCK),
      .RST_n    (RST_n),
      .iWrEn    (iWrEn),
      .iWrAddr  (iWrAddr),
      .iWrChar  (iWrChar),
      .iNumCall (iNumCall),
      .iNum     (iNum),
      .iNumPos  (iNumPos),
      .oNumBusy (oNumBusy),
      .oNumDone (oNumDone),
      .line_rom1(line_rom1),
      .line_rom2(line_rom2),
      .oCall    (oCall),
      .iDone    (iDone)
   );

   always #5 CLOCK = ~CLOCK;

   int           n_tests = 0;
   int           n_fail  = 0;
   int           cyc     = 0;
   int           n_ref   = 0;
   int           n_done  = 0;
   logic [255:0] ref_q[$];
   int           done_q[$];
   logic [7:0]   model [32];
   logic         prev_call = 1'b0;
   logic [255:0] exp_img;
   int           exp_cyc;

   always @(posedge CLOCK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [127:0] img(input int line);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = model[16*line+i];
      return r;
   endfunction

   // monitor: compare every refresh request and every number-done pulse
   always @(negedge CLOCK) begin
      if (!RST_n) begin
         prev_call = 1'b0;
      end else begin
         if (oCall && !prev_call) begin
            check("refresh_expected", 128'(ref_q.size() > 0), 128'd1);
            if (ref_q.size() > 0) begin
               exp_img = ref_q.pop_front();
               check("line_rom1", line_rom1, exp_img[255:128]);
               check("line_rom2", line_rom2, exp_img[127:0]);
            end
            n_ref++;
         end
         if (oNumDone) begin
            check("done_expected", 128'(done_q.size() > 0), 128'd1);
            if (done_q.size() > 0) begin
               exp_cyc = done_q.pop_front();
               check("num_done_cycle", 128'(cyc + 1), 128'(exp_cyc));
            end
            n_done++;
         end
         prev_call = oCall;
      end
   end

   task automatic step();
      @(negedge CLOCK);
   endtask

   task automatic push_screen();
      ref_q.push_back({img(0), img(1)});
   endtask

   task automatic wr_char(input logic [4:0] a, input logic [7:0] c);
      iWrEn = 1'b1; iWrAddr = a; iWrChar = c;
      model[a] = c;
      step();
      iWrEn = 1'b0;
   endtask

   // accept happens at the next edge T; oNumDone expected in cycle T+LAT+stalls
   task automatic num_call(input logic [15:0] v, input logic [4:0] p, input int stalls,
                           input bit expect_done);
      if (expect_done) done_q.push_back(cyc + 1 + LAT + stalls);
      iNumCall = 1'b1; iNum = v; iNumPos = p;
      step();
      iNumCall = 1'b0;
   endtask

   task automatic put_num(input int v, input logic [4:0] p);
      int d[5];
      int x;
      logic [7:0] c;
`ifdef LCD1602_ZERO_BLANK_EN
      bit lead;
      lead = 1'b1;
`endif
      x = v;
      for (int i = 4; i >= 0; i--) begin
         d[i] = x % 10;
         x = x / 10;
      end
      for (int i = 0; i < 5; i++) begin
         c = 8'h30 + 8'(d[i]);
`ifdef LCD1602_ZERO_BLANK_EN
         if (lead && d[i] == 0 && i != 4) c = 8'h20;
         else lead = 1'b0;
`endif
         model[5'(int'(p) + i)] = c;
      end
   endtask

   task automatic wait_ref(input int n0, input int limit, input string name);
      int k;
      k = 0;
      while (n_ref == n0 && k < limit) begin
         @(negedge CLOCK); #1;
         k++;
      end
      check(name, 128'(n_ref != n0), 128'd1);
   endtask

   task automatic wait_done(input int n0, input int limit, input string name);
      int k;
      k = 0;
      while (n_done == n0 && k < limit) begin
         @(negedge CLOCK); #1;
         k++;
      end
      check(name, 128'(n_done != n0), 128'd1);
   endtask

   task automatic refresh_cycle(input string name);
      int n0;
      n0 = n_ref;
      push_screen();
      iDone = 1'b1;
      step();
      iDone = 1'b0;
      wait_ref(n0, 6, name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no_finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n0;
      int d0;
      logic [127:0] old2;

      for (int i = 0; i < 32; i++) model[i] = 8'h20;

      // reset state
      push_screen();
      repeat (3) step();
      check("rst_ocall", oCall, 0);
      check("rst_busy", oNumBusy, 0);
      check("rst_done", oNumDone, 0);
      check("rst_rom1", line_rom1, img(0));
      check("rst_rom2", line_rom2, img(1));

      // automatic first refresh within 2 cycles, then iDone drops oCall
      n0 = n_ref;
      RST_n = 1'b1;
      wait_ref(n0, 2, "first_refresh");
      iDone = 1'b1;
      step();
      iDone = 1'b0;
      check("ocall_drop", oCall, 0);
      repeat (4) step();
      check("no_spurious_refresh", 128'(n_ref), 128'd1);

      // single write from idle triggers a refresh containing it
      model[0] = 8'h48;
      push_screen();
      n0 = n_ref;
      wr_char(5'd0, 8'h48);
      wait_ref(n0, 4, "refresh_h");

      // write while busy: images frozen until iDone, then a second refresh
      old2 = img(1);
      wr_char(5'd31, 8'h21);
      step();
      check("frozen_rom2", line_rom2, old2);
      check("frozen_call", oCall, 1);
      refresh_cycle("refresh_bang");

      // 1234 at line 2 start; a second call during conversion is ignored
      d0 = n_done;
      num_call(16'd1234, 5'd16, 0, 1'b1);
      check("busy_after_accept", oNumBusy, 1);
      iNumCall = 1'b1; iNum = 16'd9999; iNumPos = 5'd0;
      step();
      iNumCall = 1'b0;
      wait_done(d0, 40, "done_1234");
      step();
      check("idle_after_done", oNumBusy, 0);
      put_num(1234, 5'd16);
      refresh_cycle("refresh_1234");

      // 65535 at 30 wraps to cells 31,0,1,2
      d0 = n_done;
      num_call(16'd65535, 5'd30, 0, 1'b1);
      wait_done(d0, 40, "done_65535");
      put_num(65535, 5'd30);
      refresh_cycle("refresh_wrap");

      // 907 at 5 with char writes on alternate F_WRITE cycles (5 stalls)
      d0 = n_done;
      num_call(16'd907, 5'd5, 5, 1'b1);
      repeat (16) step();
      for (int j = 0; j < 10; j++) begin
         if (j % 2 == 0) begin
            iWrEn = 1'b1;
            iWrAddr = 5'(10 + j / 2);
            iWrChar = 8'(8'h61 + j / 2);
            model[5'(10 + j / 2)] = 8'(8'h61 + j / 2);
         end else begin
            iWrEn = 1'b0;
         end
         step();
      end
      iWrEn = 1'b0;
      wait_done(d0, 20, "done_907");
      put_num(907, 5'd5);

      // zero renders as all zeros, or a lone units digit when blanking
      d0 = n_done;
      num_call(16'd0, 5'd21, 0, 1'b1);
      wait_done(d0, 40, "done_zero");
      put_num(0, 5'd21);
      refresh_cycle("refresh_907_zero");

      // reset mid-conversion: no done, blank screen, formatter idle
      d0 = n_done;
      num_call(16'd4321, 5'd0, 0, 1'b0);
      repeat (5) step();
      RST_n = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 8'h20;
      step();
      check("midrst_busy", oNumBusy, 0);
      check("midrst_call", oCall, 0);
      check("midrst_rom1", line_rom1, img(0));
      check("midrst_rom2", line_rom2, img(1));
      push_screen();
      n0 = n_ref;
      RST_n = 1'b1;
      wait_ref(n0, 2, "refresh_after_rst");
      iDone = 1'b1;
      step();
      iDone = 1'b0;
      repeat (30) step();
      check("midrst_no_done", 128'(n_done), 128'(d0));
      check("midrst_idle", oNumBusy, 0);
      check("ref_queue_empty", 128'(ref_q.size()), 128'd0);
      check("done_queue_empty", 128'(done_q.size()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
